led_share_arbiter: RTL and testbench
====================================

Name: led_share_arbiter

Overview:
- Shares the board's 4 active-low user LEDs between up to NUM_REQ requesters, such as status, error and debug sources.
- Arbitration is round-robin with a time-slice quantum. While the LEDs are granted, they show the owner's 4-bit pattern.
- While no requester owns the LEDs, they show a free-running walking-LED heartbeat.
- Sits between the requester logic and the top-level LED pins, and is the only driver of the pins.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 1..8.
- HOLD_CYCLES, 50_000_000: quantum in clk cycles before a contended grant rotates; must be >= 1.
- IDLE_DIV_BITS, 23: heartbeat step period is 2^IDLE_DIV_BITS cycles.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, level-sensitive.
- pattern  in  4*NUM_REQ  requester i's LED pattern in bits [4i+3:4i]; 1 = LED on.
- gnt  out  NUM_REQ  one-hot grant, registered; all zero when idle.
- busy  out  1  equals OR of gnt.
- leds  out  4  LED pins, active-low, registered.

Behaviour:
- One clock, synchronous active-high reset. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE, gnt = 0, busy = 0, leds = 4'b1111 (all off).
  - rr_ptr = 0, owner = 0, hold_cnt = 0, hb_cnt = 0.
- Reset asserted mid-grant returns all state to the reset values at that edge.
- Heartbeat:
  - hb_cnt is IDLE_DIV_BITS+2 bits wide, free-running, wraps, and is never cleared except by rst.
  - pos = hb_cnt[MSB:MSB-1].
  - Idle LED value = ~(4'b0001 << pos).
- IDLE state, evaluated at each edge:
  - If req == 0: leds <= idle value, gnt stays 0.
  - Otherwise: sel = first i with req[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Then:
    - state <= HOLD, owner <= sel, gnt <= onehot(sel), hold_cnt <= 0, leds <= ~pattern[sel].
  - Grant latency: one cycle from req sampled high to gnt high.
- HOLD state, evaluated at each edge, in priority order:
  - Owner drop: if req[owner] = 0, release (no minimum hold).
  - Quantum expiry: else if hold_cnt == HOLD_CYCLES-1 and (req & ~onehot(owner)) != 0, release.
  - Otherwise: hold_cnt <= min(hold_cnt+1, HOLD_CYCLES-1), i.e. saturating, and leds <= ~pattern[owner].
  - leds therefore track live pattern changes with one cycle of lag.
- Release action:
  - state <= IDLE, gnt <= 0, leds <= idle value.
  - rr_ptr <= (owner+1) mod NUM_REQ.
  - gnt is therefore low for exactly one gap cycle before any new grant.
- Contended owner holds gnt for exactly HOLD_CYCLES cycles.
- Uncontended owner keeps gnt indefinitely while req[owner] = 1.
- A requester other than the owner that raises req mid-quantum:
  - does not shorten the quantum;
  - is eligible at the saturation point, causing rotation at the next edge.
- pattern inputs of non-owners are ignored.
- NUM_REQ = 1: rr_ptr stays 0. Quantum expiry never fires because no other requesters exist.
- hold_cnt width: $clog2(HOLD_CYCLES), minimum 1 bit.
- No combinational path from any input to any output.

Test Plan (NUM_REQ=4, HOLD_CYCLES=8, IDLE_DIV_BITS=3):
- Reset behaviour: rst high 3 cycles -> gnt=0, busy=0, leds=4'b1111. In the first cycle after rst falls, leds=4'b1110.
- Idle heartbeat: req=0 for 40 cycles after reset -> leds steps 1110 -> 1101 -> 1011 -> 0111 -> 1110. Each value lasts 8 cycles (one-cycle lag).
- Single requester: req=4'b0100, pattern[11:8]=4'hA, held 20 cycles.
  - gnt=4'b0100 and busy=1 one cycle after req rises; leds=4'b0101 for all 20 cycles, with no rotation.
  - gnt=0 one cycle after req drops.
- Full contention: req=4'b1111 constant from reset -> grants 0001, 0010, 0100, 1000, 0001 in that order.
  - Each grant lasts exactly 8 cycles with a 1-cycle gnt=0 gap between grants.
  - leds equal ~pattern of the current owner.
- Early drop: req0 is granted and req3 is asserted; req0 drops after 3 cycles of gnt.
  - gnt=0 for 1 cycle, then gnt=4'b1000, because rr_ptr=1 and req1/req2 are low.
- Reset mid-grant: rst pulsed while gnt=4'b0010 with req=4'b1111.
  - Next cycle gnt=0 and leds=1111. After rst falls, the first grant is 4'b0001 (rr_ptr reset to 0).

Source files
------------

// File: rtl/led_share_arbiter.sv
// Round-robin time-sliced sharing of four active-low user LEDs between NUM_REQ requesters.
// When no one owns the LEDs they show a free-running walking-LED heartbeat.
module led_share_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned IDLE_DIV_BITS = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   pattern,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic [3:0]             leds
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned HB_W  = IDLE_DIV_BITS + 2;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [HB_W-1:0]    r_hb_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_busy;
    logic [3:0]         r_leds;

    state_t             w_state_nxt;
    logic [PTR_W-1:0]   w_rr_nxt;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [3:0]         w_leds_nxt;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_sel;
    logic               w_found;
    logic [3:0]         w_idle;
    logic [3:0]         w_own_pat;
    logic [3:0]         w_sel_pat;

    assign w_idle    = ~(4'b0001 << r_hb_cnt[HB_W-1 -: 2]);
    assign w_own_pat = pattern[{r_owner, 2'b00} +: 4];
    assign w_sel_pat = pattern[{w_sel, 2'b00} +: 4];

    // Round-robin search starting at r_rr_ptr; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_hold_cnt;
        w_gnt_nxt   = r_gnt;
        w_leds_nxt  = r_leds;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_HOLD;
                    w_owner_nxt = w_sel;
                    w_gnt_nxt   = NUM_REQ'(1) << w_sel;
                    w_cnt_nxt   = '0;
                    w_leds_nxt  = ~w_sel_pat;
                end else begin
                    w_gnt_nxt  = '0;
                    w_leds_nxt = w_idle;
                end
            end
            ST_HOLD: begin
                if (!req[r_owner] ||
                    ((r_hold_cnt == HOLD_LAST) && ((req & ~r_gnt) != '0))) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                    w_leds_nxt  = w_idle;
                    w_rr_nxt    = PTR_W'((int'(r_owner) + 1) % int'(NUM_REQ));
                end else begin
                    if (r_hold_cnt != HOLD_LAST) begin
                        w_cnt_nxt = r_hold_cnt + CNT_W'(1);
                    end
                    w_leds_nxt = ~w_own_pat;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_hold_cnt <= '0;
            r_hb_cnt   <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_leds     <= 4'b1111;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_owner    <= w_owner_nxt;
            r_hold_cnt <= w_cnt_nxt;
            r_hb_cnt   <= r_hb_cnt + HB_W'(1);
            r_gnt      <= w_gnt_nxt;
            r_busy     <= |w_gnt_nxt;
            r_leds     <= w_leds_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign leds = r_leds;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Bench for led_share_arbiter: directed vector table, hand sequences and random traffic
// checked every cycle against a cycle-count based reference model.
module tb_led_share_arbiter;

    localparam int NR = 4;
    localparam int HC = 8;
    localparam int DB = 3;
    localparam int HB_MOD = 1 << (DB + 2);

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] pattern;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  leds;

    always #5 clk = ~clk;

    led_share_arbiter #(
        .NUM_REQ      (NR),
        .HOLD_CYCLES  (HC),
        .IDLE_DIV_BITS(DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .pattern(pattern),
        .gnt    (gnt),
        .busy   (busy),
        .leds   (leds)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner plus number of cycles it has held the grant.
    bit         m_busy;
    int         m_owner, m_rr, m_held, m_hb;
    logic [3:0] e_gnt, e_leds;
    logic       e_busy;

    function automatic logic [3:0] pat_of(int i);
        logic [15:0] sh;
        sh = pattern >> (4 * i);
        return sh[3:0];
    endfunction

    function automatic logic [3:0] idle_val(int hb);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((hb / (1 << DB)) % 4));
    endfunction

    task automatic model_step();
        int sel;
        logic [3:0] idle, others, one;
        one = 4'b0001;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_rr = 0; m_held = 0; m_hb = 0;
            e_gnt = 4'b0000; e_leds = 4'b1111;
        end else begin
            idle = idle_val(m_hb);
            if (!m_busy) begin
                sel = -1;
                for (int k = 0; k < NR; k++)
                    if (sel < 0 && req[(m_rr + k) % NR]) sel = (m_rr + k) % NR;
                if (sel < 0) begin
                    e_gnt = 4'b0000; e_leds = idle;
                end else begin
                    m_busy = 1; m_owner = sel; m_held = 1;
                    e_gnt = one << sel; e_leds = ~pat_of(sel);
                end
            end else begin
                others = req & ~(one << m_owner);
                if (!req[m_owner] || (m_held >= HC && others != 4'b0000)) begin
                    m_busy = 0; m_rr = (m_owner + 1) % NR;
                    e_gnt = 4'b0000; e_leds = idle;
                end else begin
                    m_held++;
                    e_leds = ~pat_of(m_owner);
                end
            end
            m_hb = (m_hb + 1) % HB_MOD;
        end
        e_busy = m_busy;
    endtask

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // One clock: model follows the same sampled inputs, outputs compared after the edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model_gnt", gnt, e_gnt);
        chk("model_busy", {3'b000, busy}, {3'b000, e_busy});
        chk("model_leds", leds, e_leds);
    endtask

    task automatic do_reset(int n);
        rst = 1'b1; req = 4'b0000;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic       busy;
        logic [3:0] leds;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [3:0] one;
        logic [3:0] exp_g;
        bit found;
        one = 4'b0001;
        rst = 1'b1; req = 4'b0000; pattern = 16'h3A5C;

        // rst, req -> gnt, busy, leds after the edge
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1111};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1111};
        tbl[2]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b1111};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1110};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0101};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0101};
        tbl[6]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 4'b0101};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1110};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0011};
        tbl[9]  = '{1'b0, 4'b1001, 4'b0001, 1'b1, 4'b0011};
        tbl[10] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1110};
        tbl[11] = '{1'b0, 4'b1000, 4'b1000, 1'b1, 4'b1100};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst; req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_busy", i), {3'b000, busy}, {3'b000, tbl[i].busy});
            chk($sformatf("tbl%0d_leds", i), leds, tbl[i].leds);
        end

        // Idle heartbeat: each position lasts 2^DB cycles.
        do_reset(3);
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk($sformatf("hb_t%0d", t), leds, ~(one << (((t - 1) / 8) % 4)));
        end

        // Single uncontended requester keeps the grant indefinitely.
        do_reset(2);
        pattern = 16'h3A5C;
        req = 4'b0100;
        for (int t = 0; t < 20; t++) begin
            tick();
            chk($sformatf("single_gnt_t%0d", t), gnt, 4'b0100);
            chk($sformatf("single_leds_t%0d", t), leds, 4'b0101);
        end
        req = 4'b0000;
        tick();
        chk("single_drop_gnt", gnt, 4'b0000);

        // Full contention: 8-cycle grants in order with one-cycle gaps.
        do_reset(3);
        pattern = 16'h9E71;
        req = 4'b1111;
        for (int t = 1; t <= 45; t++) begin
            tick();
            exp_g = (((t - 1) % 9) == 8) ? 4'b0000 : (one << (((t - 1) / 9) % 4));
            chk($sformatf("cont_gnt_t%0d", t), gnt, exp_g);
        end

        // Reset mid-grant returns to rr_ptr 0.
        do_reset(2);
        req = 4'b1111;
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick();
            if (gnt == 4'b0010) found = 1;
        end
        chk("midrst_reach_gnt1", {3'b000, found}, 4'b0001);
        rst = 1'b1;
        tick();
        chk("midrst_gnt", gnt, 4'b0000);
        chk("midrst_leds", leds, 4'b1111);
        rst = 1'b0;
        tick();
        chk("midrst_regrant", gnt, 4'b0001);

        // Random traffic against the model.
        do_reset(2);
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) pattern = 16'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
